// File: rtl/axi_id_remap.sv
// AXI ID remapper: squeezes wide slave-side IDs into a small slot index and restores them on R/B.
// Optional SVA checks are compiled in when AXI_ID_REMAP_ASSERT_EN is defined.
`timescale 1ns/1ps

module axi_id_remap_table #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 2,
   parameter int MAX   = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             i_req_valid,
   input  logic [IN_W-1:0]  i_req_id,
   input  logic             i_req_ready,
   output logic             o_req_avail,
   output logic [OUT_W-1:0] o_req_slot,
   input  logic             i_rsp_valid,
   input  logic             i_rsp_ready,
   input  logic             i_rsp_last,
   input  logic [OUT_W-1:0] i_rsp_slot,
   output logic [IN_W-1:0]  o_rsp_id
);

   localparam int NB_SLOTS = 1 << OUT_W;
   localparam int CNT_W    = $clog2(MAX + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   typedef struct packed {
      logic             valid;
      logic [IN_W-1:0]  orig_id;
      logic [CNT_W-1:0] cnt;
   } slot_t;

   slot_t            r_tab [NB_SLOTS];
   logic             w_hit;
   logic [OUT_W-1:0] w_hit_slot;
   logic             w_free;
   logic [OUT_W-1:0] w_free_slot;
   logic             w_inc;
   logic             w_dec;

   // Lowest-index match wins; an ID never occupies two slots so ordering per ID is preserved.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
      w_hit       = 1'b0;
      w_hit_slot  = '0;
      w_free      = 1'b0;
      w_free_slot = '0;
      for (int i = 0; i < NB_SLOTS; i++) begin
         if (!w_hit && r_tab[i].valid && (r_tab[i].orig_id == i_req_id)) begin
            w_hit      = 1'b1;
            w_hit_slot = OUT_W'(i);
         end
         if (!w_free && !r_tab[i].valid) begin
            w_free      = 1'b1;
            w_free_slot = OUT_W'(i);
         end
      end
   end

   assign o_req_avail = w_hit ? (r_tab[w_hit_slot].cnt < MAX_CNT) : w_free;
   assign o_req_slot  = w_hit ? w_hit_slot : w_free_slot;
   assign o_rsp_id    = r_tab[i_rsp_slot].orig_id;

   assign w_inc = i_req_valid && i_req_ready && o_req_avail;
   // A response on an idle slot leaves the counter saturated at zero.
   assign w_dec = i_rsp_valid && i_rsp_ready && i_rsp_last && (r_tab[i_rsp_slot].cnt != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the table is small flop storage, so every entry is reset; a RAM would not be.
         for (int i = 0; i < NB_SLOTS; i++) begin
            r_tab[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NB_SLOTS; i++) begin
            // NOTE: sequential state uses non-blocking assignments only.
            if (w_inc && (o_req_slot == OUT_W'(i)) && !(w_dec && (i_rsp_slot == OUT_W'(i)))) begin
               r_tab[i].valid   <= 1'b1;
               r_tab[i].orig_id <= i_req_id;
               r_tab[i].cnt     <= r_tab[i].cnt + ONE_CNT;
            end else if (w_dec && (i_rsp_slot == OUT_W'(i)) && !(w_inc && (o_req_slot == OUT_W'(i)))) begin
               r_tab[i].cnt <= r_tab[i].cnt - ONE_CNT;
               if (r_tab[i].cnt == ONE_CNT) begin
                  r_tab[i].valid <= 1'b0;
               end
            end else if (w_inc && (o_req_slot == OUT_W'(i))) begin
               r_tab[i].valid   <= 1'b1;
               r_tab[i].orig_id <= i_req_id;
            end
         end
      end
   end

`ifdef AXI_ID_REMAP_ASSERT_EN
   a_rsp_on_free_slot : assert property (@(posedge clk_i) disable iff (!rst_ni)
      i_rsp_valid |-> r_tab[i_rsp_slot].valid)
      else $error("axi_id_remap: response on free slot %0d", i_rsp_slot);
   a_dec_at_zero : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (i_rsp_valid && i_rsp_ready && i_rsp_last) |-> (r_tab[i_rsp_slot].cnt != '0))
      else $error("axi_id_remap: decrement at zero on slot %0d", i_rsp_slot);
   a_inc_at_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
      w_inc |-> (r_tab[o_req_slot].cnt != MAX_CNT))
      else $error("axi_id_remap: increment at max on slot %0d", o_req_slot);
   a_valid_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (i_req_valid && o_req_avail && !i_req_ready) |=> (i_req_valid && o_req_avail))
      else $error("axi_id_remap: request valid dropped before ready");
   a_id_known : assert property (@(posedge clk_i) disable iff (!rst_ni)
      i_req_valid |-> !$isunknown(i_req_id))
      else $error("axi_id_remap: unknown ID while valid");
`else
   // Checks compiled out; datapath above is identical.
`endif

endmodule

module axi_id_remap #(
   parameter int AXI_ADDR_WIDTH   = 32,
   parameter int AXI_DATA_WIDTH   = 32,
   parameter int AXI_USER_WIDTH   = 1,
   parameter int AXI_ID_IN_WIDTH  = 12,
   parameter int AXI_ID_OUT_WIDTH = 2,
   parameter int MAX_TXNS_PER_ID  = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   // slave side AW
   input  logic [AXI_ID_IN_WIDTH-1:0]  i_slv_aw_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   i_slv_aw_addr,
   input  logic [7:0]                  i_slv_aw_len,
   input  logic [2:0]                  i_slv_aw_size,
   input  logic [1:0]                  i_slv_aw_burst,
   input  logic                        i_slv_aw_lock,
   input  logic [3:0]                  i_slv_aw_cache,
   input  logic [2:0]                  i_slv_aw_prot,
   input  logic [3:0]                  i_slv_aw_qos,
   input  logic [3:0]                  i_slv_aw_region,
   input  logic [AXI_USER_WIDTH-1:0]   i_slv_aw_user,
   input  logic                        i_slv_aw_valid,
   output logic                        o_slv_aw_ready,
   // slave side W
   input  logic [AXI_DATA_WIDTH-1:0]   i_slv_w_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] i_slv_w_strb,
   input  logic                        i_slv_w_last,
   input  logic [AXI_USER_WIDTH-1:0]   i_slv_w_user,
   input  logic                        i_slv_w_valid,
   output logic                        o_slv_w_ready,
   // slave side B
   output logic [AXI_ID_IN_WIDTH-1:0]  o_slv_b_id,
   output logic [1:0]                  o_slv_b_resp,
   output logic [AXI_USER_WIDTH-1:0]   o_slv_b_user,
   output logic                        o_slv_b_valid,
   input  logic                        i_slv_b_ready,
   // slave side AR
   input  logic [AXI_ID_IN_WIDTH-1:0]  i_slv_ar_id,
   input  logic [AXI_ADDR_WIDTH-1:0]   i_slv_ar_addr,
   input  logic [7:0]                  i_slv_ar_len,
   input  logic [2:0]                  i_slv_ar_size,
   input  logic [1:0]                  i_slv_ar_burst,
   input  logic                        i_slv_ar_lock,
   input  logic [3:0]                  i_slv_ar_cache,
   input  logic [2:0]                  i_slv_ar_prot,
   input  logic [3:0]                  i_slv_ar_qos,
   input  logic [3:0]                  i_slv_ar_region,
   input  logic [AXI_USER_WIDTH-1:0]   i_slv_ar_user,
   input  logic                        i_slv_ar_valid,
   output logic                        o_slv_ar_ready,
   // slave side R
   output logic [AXI_ID_IN_WIDTH-1:0]  o_slv_r_id,
   output logic [AXI_DATA_WIDTH-1:0]   o_slv_r_data,
   output logic [1:0]                  o_slv_r_resp,
   output logic                        o_slv_r_last,
   output logic [AXI_USER_WIDTH-1:0]   o_slv_r_user,
   output logic                        o_slv_r_valid,
   input  logic                        i_slv_r_ready,
   // master side AW
   output logic [AXI_ID_OUT_WIDTH-1:0] o_mst_aw_id,
   output logic [AXI_ADDR_WIDTH-1:0]   o_mst_aw_addr,
   output logic [7:0]                  o_mst_aw_len,
   output logic [2:0]                  o_mst_aw_size,
   output logic [1:0]                  o_mst_aw_burst,
   output logic                        o_mst_aw_lock,
   output logic [3:0]                  o_mst_aw_cache,
   output logic [2:0]                  o_mst_aw_prot,
   output logic [3:0]                  o_mst_aw_qos,
   output logic [3:0]                  o_mst_aw_region,
   output logic [AXI_USER_WIDTH-1:0]   o_mst_aw_user,
   output logic                        o_mst_aw_valid,
   input  logic                        i_mst_aw_ready,
   // master side W
   output logic [AXI_DATA_WIDTH-1:0]   o_mst_w_data,
   output logic [AXI_DATA_WIDTH/8-1:0] o_mst_w_strb,
   output logic                        o_mst_w_last,
   output logic [AXI_USER_WIDTH-1:0]   o_mst_w_user,
   output logic                        o_mst_w_valid,
   input  logic                        i_mst_w_ready,
   // master side B
   input  logic [AXI_ID_OUT_WIDTH-1:0] i_mst_b_id,
   input  logic [1:0]                  i_mst_b_resp,
   input  logic [AXI_USER_WIDTH-1:0]   i_mst_b_user,
   input  logic                        i_mst_b_valid,
   output logic                        o_mst_b_ready,
   // master side AR
   output logic [AXI_ID_OUT_WIDTH-1:0] o_mst_ar_id,
   output logic [AXI_ADDR_WIDTH-1:0]   o_mst_ar_addr,
   output logic [7:0]                  o_mst_ar_len,
   output logic [2:0]                  o_mst_ar_size,
   output logic [1:0]                  o_mst_ar_burst,
   output logic                        o_mst_ar_lock,
   output logic [3:0]                  o_mst_ar_cache,
   output logic [2:0]                  o_mst_ar_prot,
   output logic [3:0]                  o_mst_ar_qos,
   output logic [3:0]                  o_mst_ar_region,
   output logic [AXI_USER_WIDTH-1:0]   o_mst_ar_user,
   output logic                        o_mst_ar_valid,
   input  logic                        i_mst_ar_ready,
   // master side R
   input  logic [AXI_ID_OUT_WIDTH-1:0] i_mst_r_id,
   input  logic [AXI_DATA_WIDTH-1:0]   i_mst_r_data,
   input  logic [1:0]                  i_mst_r_resp,
   input  logic                        i_mst_r_last,
   input  logic [AXI_USER_WIDTH-1:0]   i_mst_r_user,
   input  logic                        i_mst_r_valid,
   output logic                        o_mst_r_ready
);

   logic                        w_ar_avail;
   logic [AXI_ID_OUT_WIDTH-1:0] w_ar_slot;
   logic                        w_aw_avail;
   logic [AXI_ID_OUT_WIDTH-1:0] w_aw_slot;

   axi_id_remap_table #(
      .IN_W  (AXI_ID_IN_WIDTH),
      .OUT_W (AXI_ID_OUT_WIDTH),
      .MAX   (MAX_TXNS_PER_ID)
   ) u_rd_table (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .i_req_valid (i_slv_ar_valid),
      .i_req_id    (i_slv_ar_id),
      .i_req_ready (i_mst_ar_ready),
      .o_req_avail (w_ar_avail),
      .o_req_slot  (w_ar_slot),
      .i_rsp_valid (i_mst_r_valid),
      .i_rsp_ready (i_slv_r_ready),
      .i_rsp_last  (i_mst_r_last),
      .i_rsp_slot  (i_mst_r_id),
      .o_rsp_id    (o_slv_r_id)
   );

   // Write responses have no last beat; every B handshake retires one burst.
   axi_id_remap_table #(
      .IN_W  (AXI_ID_IN_WIDTH),
      .OUT_W (AXI_ID_OUT_WIDTH),
      .MAX   (MAX_TXNS_PER_ID)
   ) u_wr_table (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .i_req_valid (i_slv_aw_valid),
      .i_req_id    (i_slv_aw_id),
      .i_req_ready (i_mst_aw_ready),
      .o_req_avail (w_aw_avail),
      .o_req_slot  (w_aw_slot),
      .i_rsp_valid (i_mst_b_valid),
      .i_rsp_ready (i_slv_b_ready),
      .i_rsp_last  (1'b1),
      .i_rsp_slot  (i_mst_b_id),
      .o_rsp_id    (o_slv_b_id)
   );

   assign o_mst_ar_valid  = i_slv_ar_valid && w_ar_avail;
   assign o_slv_ar_ready  = i_mst_ar_ready && w_ar_avail;
   assign o_mst_ar_id     = w_ar_slot;
   assign o_mst_ar_addr   = i_slv_ar_addr;
   assign o_mst_ar_len    = i_slv_ar_len;
   assign o_mst_ar_size   = i_slv_ar_size;
   assign o_mst_ar_burst  = i_slv_ar_burst;
   assign o_mst_ar_lock   = i_slv_ar_lock;
   assign o_mst_ar_cache  = i_slv_ar_cache;
   assign o_mst_ar_prot   = i_slv_ar_prot;
   assign o_mst_ar_qos    = i_slv_ar_qos;
   assign o_mst_ar_region = i_slv_ar_region;
   assign o_mst_ar_user   = i_slv_ar_user;

   assign o_mst_aw_valid  = i_slv_aw_valid && w_aw_avail;
   assign o_slv_aw_ready  = i_mst_aw_ready && w_aw_avail;
   assign o_mst_aw_id     = w_aw_slot;
   assign o_mst_aw_addr   = i_slv_aw_addr;
   assign o_mst_aw_len    = i_slv_aw_len;
   assign o_mst_aw_size   = i_slv_aw_size;
   assign o_mst_aw_burst  = i_slv_aw_burst;
   assign o_mst_aw_lock   = i_slv_aw_lock;
   assign o_mst_aw_cache  = i_slv_aw_cache;
   assign o_mst_aw_prot   = i_slv_aw_prot;
   assign o_mst_aw_qos    = i_slv_aw_qos;
   assign o_mst_aw_region = i_slv_aw_region;
   assign o_mst_aw_user   = i_slv_aw_user;

   assign o_mst_w_data    = i_slv_w_data;
   assign o_mst_w_strb    = i_slv_w_strb;
   assign o_mst_w_last    = i_slv_w_last;
   assign o_mst_w_user    = i_slv_w_user;
   assign o_mst_w_valid   = i_slv_w_valid;
   assign o_slv_w_ready   = i_mst_w_ready;

   assign o_slv_r_data    = i_mst_r_data;
   assign o_slv_r_resp    = i_mst_r_resp;
   assign o_slv_r_last    = i_mst_r_last;
   assign o_slv_r_user    = i_mst_r_user;
   assign o_slv_r_valid   = i_mst_r_valid;
   assign o_mst_r_ready   = i_slv_r_ready;

   assign o_slv_b_resp    = i_mst_b_resp;
   assign o_slv_b_user    = i_mst_b_user;
   assign o_slv_b_valid   = i_mst_b_valid;
   assign o_mst_b_ready   = i_slv_b_ready;

endmodule
